// File: rtl/nvram_upload_pkg.sv
// Shared constants for the NVRAM upload path: FSM state encodings, interface
// widths and the fill byte returned for reads that never reach memory.
package nvram_upload_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int IOCTL_AW = 25;
    localparam int IDX_W    = 8;
    localparam int CNT_W    = 16;

    localparam logic [7:0]       FILL_BYTE = 8'hFF;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

endpackage

// File: rtl/nvram_upload.sv
// Core-to-HPS upload of the high-score/NVRAM memory: each ioctl_rd for our
// index fetches one byte over a req/ack memory port while stalling hps_io.
module nvram_upload
    import nvram_upload_pkg::*;
#(
    parameter logic [IDX_W-1:0] INDEX   = 8'd4,
    parameter int               MEM_AW  = 10,
    parameter int               SIZE    = 1024,
    parameter int               TIMEOUT = 255
) (
    input  logic                clk_sys,
    input  logic                RESET,
    input  logic                ioctl_upload,
    input  logic [IDX_W-1:0]    ioctl_index,
    input  logic                ioctl_rd,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    output logic [7:0]          ioctl_din,
    output logic                ioctl_wait,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic                mem_rd,
    input  logic [7:0]          mem_data,
    input  logic                mem_ack,
    output logic                busy,
    output logic                upload_done,
    output logic [CNT_W-1:0]    byte_count,
    output logic                err_timeout
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic                sel;
    logic                in_range;
    logic                served;
    logic                tmo_hit;

    logic [1:0]          state_q, state_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                wait_q, wait_d;
    logic [7:0]          din_q, din_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic                sel_q;
    logic [CNT_W-1:0]    byte_count_q, byte_count_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    assign sel      = ioctl_upload && (ioctl_index == INDEX);
    // All 25 address bits take part so aliased addresses read as fill bytes.
    assign in_range = ioctl_addr < IOCTL_AW'(SIZE);

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        wait_d     = wait_q;
        din_d      = din_q;
        tmo_cnt_d  = tmo_cnt_q;
        served     = 1'b0;
        tmo_hit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ioctl_rd && sel) begin
                    if (in_range) begin
                        mem_addr_d = ioctl_addr[MEM_AW-1:0];
                        mem_rd_d   = 1'b1;
                        wait_d     = 1'b1;
                        tmo_cnt_d  = '0;
                        state_d    = ST_REQ;
                    end else begin
                        din_d  = FILL_BYTE;
                        served = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // Losing the session abandons the fetch without counting it.
                if (!sel) begin
                    mem_rd_d = 1'b0;
                    wait_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (mem_ack) begin
                    din_d    = mem_data;
                    mem_rd_d = 1'b0;
                    wait_d   = 1'b0;
                    served   = 1'b1;
                    state_d  = ST_DONE;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    din_d    = FILL_BYTE;
                    mem_rd_d = 1'b0;
                    wait_d   = 1'b0;
                    served   = 1'b1;
                    tmo_hit  = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                mem_rd_d = 1'b0;
                wait_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        byte_count_d = (sel && !sel_q) ? '0 : byte_count_q;
        err_d        = (sel && !sel_q) ? 1'b0 : err_q;
        if (served && byte_count_d != CNT_MAX) begin
            byte_count_d = byte_count_d + CNT_W'(1);
        end
        if (tmo_hit) begin
            err_d = 1'b1;
        end
        done_d = !sel && sel_q && (byte_count_q != '0);
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            wait_q       <= 1'b0;
            din_q        <= '0;
            tmo_cnt_q    <= '0;
            sel_q        <= 1'b0;
            byte_count_q <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            wait_q       <= wait_d;
            din_q        <= din_d;
            tmo_cnt_q    <= tmo_cnt_d;
            sel_q        <= sel;
            byte_count_q <= byte_count_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    assign ioctl_din   = din_q;
    assign ioctl_wait  = wait_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign busy        = sel_q;
    assign upload_done = done_q;
    assign byte_count  = byte_count_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_nvram_upload.sv
// Directed bench for nvram_upload with a small acknowledging memory model.
module tb_nvram_upload;

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [9:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic        busy;
    logic        upload_done;
    logic [15:0] byte_count;
    logic        err_timeout;

    int vectors     = 0;
    int miscompares = 0;

    logic ack_en  = 1'b1;
    int   ack_dly = 1;
    int   rd_cycles = 0;
    int   rise_cnt  = 0;

    nvram_upload dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .ioctl_upload(ioctl_upload),
        .ioctl_index (ioctl_index),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .upload_done (upload_done),
        .byte_count  (byte_count),
        .err_timeout (err_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    task step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_byte(input logic [24:0] a, output logic [7:0] d);
        int n;
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        step();
        ioctl_rd = 1'b0;
        n = 0;
        while (ioctl_wait === 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("wait_bound", 32'(n < 50), 32'd1);
        d = ioctl_din;
        step();
    endtask

    // Memory: acks ack_dly cycles after mem_rd rises, data = addr[7:0] ^ 8'hA0.
    initial begin
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(posedge clk_sys);
            #1;
            mem_ack = 1'b0;
            if (mem_rd === 1'b1) begin
                rd_cycles++;
                if (rd_cycles == 1) rise_cnt++;
                if (ack_en && rd_cycles == ack_dly + 1) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_addr[7:0] ^ 8'hA0;
                end
            end else begin
                rd_cycles = 0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int n;
        int rise_base;

        RESET = 1'b1; ioctl_upload = 1'b1; ioctl_index = 8'd4;
        ioctl_rd = 1'b0; ioctl_addr = '0;
        step(); step(); step();
        check("rst_din",   32'(ioctl_din),   32'h00);
        check("rst_wait",  32'(ioctl_wait),  32'h0);
        check("rst_memrd", 32'(mem_rd),      32'h0);
        check("rst_maddr", 32'(mem_addr),    32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        check("rst_done",  32'(upload_done), 32'h0);
        check("rst_count", 32'(byte_count),  32'h0);
        check("rst_err",   32'(err_timeout), 32'h0);
        RESET = 1'b0;
        step();
        check("busy_on", 32'(busy), 32'h1);

        // Basic read, ack one cycle after mem_rd
        ack_dly = 1;
        ioctl_rd = 1'b1; ioctl_addr = 25'h005;
        step();
        ioctl_rd = 1'b0;
        check("t1_wait_c1",  32'(ioctl_wait), 32'h1);
        check("t1_memrd_c1", 32'(mem_rd),     32'h1);
        check("t1_maddr",    32'(mem_addr),   32'h005);
        step();
        check("t1_wait_c2",  32'(ioctl_wait), 32'h1);
        check("t1_memrd_c2", 32'(mem_rd),     32'h1);
        step();
        check("t1_wait_c3",  32'(ioctl_wait), 32'h0);
        check("t1_memrd_c3", 32'(mem_rd),     32'h0);
        check("t1_din",      32'(ioctl_din),  32'hA5);
        check("t1_count",    32'(byte_count), 32'h1);
        // Strobe landing in DONE must be dropped
        ioctl_rd = 1'b1; ioctl_addr = 25'h006;
        step();
        ioctl_rd = 1'b0;
        check("done_rd_memrd", 32'(mem_rd),     32'h0);
        check("done_rd_wait",  32'(ioctl_wait), 32'h0);
        step();
        check("done_rd_memrd2", 32'(mem_rd),     32'h0);
        check("done_rd_count",  32'(byte_count), 32'h1);
        check("done_rd_din",    32'(ioctl_din),  32'hA5);

        // Other index: session for us ends, reads ignored
        ioctl_index = 8'd3;
        step();
        check("t2_done_pulse", 32'(upload_done), 32'h1);
        check("t2_busy",       32'(busy),        32'h0);
        ioctl_rd = 1'b1; ioctl_addr = 25'h000;
        step();
        ioctl_rd = 1'b0;
        check("t2_memrd", 32'(mem_rd),      32'h0);
        check("t2_wait",  32'(ioctl_wait),  32'h0);
        check("t2_din",   32'(ioctl_din),   32'hA5);
        check("t2_done0", 32'(upload_done), 32'h0);
        step();
        check("t2_memrd2", 32'(mem_rd), 32'h0);

        // Out-of-range addresses return fill byte with no memory access
        ioctl_index = 8'd4;
        step();
        check("t3_count0", 32'(byte_count), 32'h0);
        check("t3_busy",   32'(busy),       32'h1);
        ioctl_rd = 1'b1; ioctl_addr = 25'd1024;
        step();
        ioctl_rd = 1'b0;
        check("t3_din",   32'(ioctl_din),  32'hFF);
        check("t3_memrd", 32'(mem_rd),     32'h0);
        check("t3_wait",  32'(ioctl_wait), 32'h0);
        check("t3_count", 32'(byte_count), 32'h1);
        ioctl_rd = 1'b1; ioctl_addr = 25'h1000005;
        step();
        ioctl_rd = 1'b0;
        check("t3_alias_din",   32'(ioctl_din),  32'hFF);
        check("t3_alias_memrd", 32'(mem_rd),     32'h0);
        check("t3_alias_wait",  32'(ioctl_wait), 32'h0);
        check("t3_alias_count", 32'(byte_count), 32'h2);
        step();

        // Timeout: no ack at all
        ack_en = 1'b0;
        ioctl_rd = 1'b1; ioctl_addr = 25'h007;
        step();
        ioctl_rd = 1'b0;
        n = 0;
        while (mem_rd === 1'b1 && n < 400) begin
            n++;
            step();
        end
        check("t4_req_cycles", 32'(n),           32'd255);
        check("t4_wait",       32'(ioctl_wait),  32'h0);
        check("t4_din",        32'(ioctl_din),   32'hFF);
        check("t4_err",        32'(err_timeout), 32'h1);
        check("t4_count",      32'(byte_count),  32'h3);
        step();
        // Best case latency, and err stays sticky
        ack_en = 1'b1; ack_dly = 0;
        ioctl_rd = 1'b1; ioctl_addr = 25'h005;
        step();
        ioctl_rd = 1'b0;
        check("t4b_wait1", 32'(ioctl_wait), 32'h1);
        step();
        check("t4b_wait2", 32'(ioctl_wait),  32'h0);
        check("t4b_din",   32'(ioctl_din),   32'hA5);
        check("t4b_err",   32'(err_timeout), 32'h1);
        check("t4b_count", 32'(byte_count),  32'h4);
        step();

        // New session clears count and error; full sequential sweep
        ioctl_upload = 1'b0;
        step();
        check("t5_done_prev", 32'(upload_done), 32'h1);
        ioctl_upload = 1'b1;
        step();
        check("t5_count0", 32'(byte_count),  32'h0);
        check("t5_err0",   32'(err_timeout), 32'h0);
        ack_dly = 1;
        rise_base = rise_cnt;
        for (int a = 0; a < 1024; a++) begin
            rd_byte(25'(a), d);
            check("t5_data", 32'(d), 32'(8'(a) ^ 8'hA0));
        end
        check("t5_count",  32'(byte_count),         32'd1024);
        check("t5_reqs",   32'(rise_cnt - rise_base), 32'd1024);
        check("t5_nodone", 32'(upload_done),        32'h0);
        ioctl_upload = 1'b0;
        step();
        check("t5_done",  32'(upload_done), 32'h1);
        step();
        check("t5_done1", 32'(upload_done), 32'h0);

        // Session drop in the 2nd REQ cycle aborts the fetch
        ioctl_upload = 1'b1;
        step();
        rd_byte(25'h009, d);
        check("t6_pre_data",  32'(d),          32'hA9);
        check("t6_pre_count", 32'(byte_count), 32'h1);
        ack_en = 1'b0;
        ioctl_rd = 1'b1; ioctl_addr = 25'h00A;
        step();
        ioctl_rd = 1'b0;
        check("t6_memrd_c1", 32'(mem_rd), 32'h1);
        step();
        ioctl_upload = 1'b0;
        step();
        check("t6_memrd", 32'(mem_rd),      32'h0);
        check("t6_wait",  32'(ioctl_wait),  32'h0);
        check("t6_count", 32'(byte_count),  32'h1);
        check("t6_done",  32'(upload_done), 32'h1);
        check("t6_din",   32'(ioctl_din),   32'hA9);
        ioctl_upload = 1'b1;
        ack_en = 1'b1; ack_dly = 0;
        step();
        rd_byte(25'h005, d);
        check("t6_idle_data",  32'(d),          32'hA5);
        check("t6_idle_count", 32'(byte_count), 32'h1);

        // Reset in the 2nd REQ cycle
        ack_en = 1'b0;
        ioctl_rd = 1'b1; ioctl_addr = 25'h00B;
        step();
        ioctl_rd = 1'b0;
        step();
        RESET = 1'b1;
        step();
        check("t7_memrd", 32'(mem_rd),      32'h0);
        check("t7_wait",  32'(ioctl_wait),  32'h0);
        check("t7_din",   32'(ioctl_din),   32'h00);
        check("t7_maddr", 32'(mem_addr),    32'h0);
        check("t7_busy",  32'(busy),        32'h0);
        check("t7_done",  32'(upload_done), 32'h0);
        check("t7_count", 32'(byte_count),  32'h0);
        check("t7_err",   32'(err_timeout), 32'h0);
        RESET = 1'b0;
        step();
        check("t7_busy_on", 32'(busy), 32'h1);
        ack_en = 1'b1;
        rd_byte(25'h005, d);
        check("t7_idle_data",  32'(d),          32'hA5);
        check("t7_idle_count", 32'(byte_count), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nvram_upload.md
Name: nvram_upload

Overview:
- Serves the core-to-HPS (upload) direction of the ioctl file interface, the counterpart of the ROM download path.
- When the HPS requests an upload for this block's index, each ioctl_rd strobe fetches one byte from the shared high-score/NVRAM memory through a request/acknowledge port.
- It holds ioctl_wait while the fetch is in progress, then presents the byte on ioctl_din.
- Sits beside hps_io in the emu top; its memory port is arbitrated by the game core's RAM mux.

Parameters:
- INDEX, 8'd4, ioctl_index value that selects this block.
- MEM_AW, 10, memory address width.
- SIZE, 1024, number of valid bytes; must be <= 2**MEM_AW.
- TIMEOUT, 255, maximum clk_sys cycles to wait for mem_ack before giving up on a byte.

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- ioctl_upload  in  1  HPS upload session active
- ioctl_index  in  8  file index of the current session
- ioctl_rd  in  1  one-cycle read strobe from hps_io
- ioctl_addr  in  25  byte address of the current read
- ioctl_din  out  8  byte returned to hps_io
- ioctl_wait  out  1  stall towards hps_io; 1 = byte not ready yet
- mem_addr  out  MEM_AW  memory byte address
- mem_rd  out  1  read request, held until acknowledged
- mem_data  in  8  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle acknowledge from the memory arbiter
- busy  out  1  session active for INDEX
- upload_done  out  1  one-cycle pulse at end of a session that served at least one byte
- byte_count  out  16  bytes served in the current or last session (saturates at 16'hFFFF)
- err_timeout  out  1  sticky flag; a read timed out in this session

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is synchronous and active-high on RESET.
- Reset values: all outputs 0, including ioctl_din=8'h00. State = IDLE. Reset mid-transaction drops mem_rd and ioctl_wait on the next edge.
- sel = ioctl_upload && (ioctl_index == INDEX). busy is sel registered.
- States: IDLE, REQ, DONE.
- IDLE:
  - On ioctl_rd && sel with addr < SIZE: latch mem_addr <= addr[MEM_AW-1:0]; set mem_rd=1, ioctl_wait=1, clear the timeout counter; go to REQ.
  - On ioctl_rd && sel with addr >= SIZE: ioctl_din <= 8'hFF, no memory access, ioctl_wait stays 0, byte_count += 1; stay in IDLE.
  - ioctl_rd with !sel is ignored; outputs are unchanged.
- REQ:
  - mem_rd stays high. mem_addr is stable.
  - On mem_ack: ioctl_din <= mem_data, mem_rd=0, ioctl_wait=0, byte_count += 1; go to DONE.
  - Otherwise, when the counter reaches TIMEOUT: ioctl_din <= 8'hFF, err_timeout=1, mem_rd=0, ioctl_wait=0, byte_count += 1; go to DONE.
- DONE: unconditional single cycle back to IDLE. Guarantees at least one idle cycle between memory requests.
- Latency: ioctl_wait rises the cycle after ioctl_rd. Best case (ack in the first REQ cycle), ioctl_din is valid and ioctl_wait falls 2 cycles after ioctl_rd.
- ioctl_rd arriving in REQ or DONE is ignored; hps_io never strobes while wait is high.
- ioctl_din holds its last value until the next served read.
- Session start (rising edge of sel): byte_count=0, err_timeout=0.
- Session end:
  - Falling edge of sel: if byte_count != 0, upload_done pulses for one cycle.
  - If sel falls during REQ: abort to IDLE next cycle, mem_rd=0, ioctl_wait=0, no count increment. upload_done still follows the rule above.
- mem_ack seen outside REQ is ignored.
- Address arithmetic: comparison against SIZE uses all 25 address bits, so addresses that would alias beyond the memory get 8'hFF.

Decomposition:
- Shared package: state enum, sel/edge helper widths, the constant 8'hFF fill byte.
- No sub-module. One always block for the FSM plus one for session bookkeeping; the timeout counter is inline, sized by $clog2(TIMEOUT+1).

Test Plan:
- Index 4, rd at addr 0x005, memory acks 1 cycle after mem_rd with 8'hA5 -> mem_addr=5, ioctl_wait high for exactly 2 cycles, ioctl_din=8'hA5, byte_count=1.
- Index 3 session, rd at addr 0 -> no mem_rd, ioctl_wait=0, ioctl_din unchanged, busy=0.
- Index 4, rd at addr 1024 (SIZE=1024) -> ioctl_din=8'hFF, no mem_rd, ioctl_wait never high, byte_count increments.
- Memory never acks, TIMEOUT=255 -> mem_rd drops and ioctl_wait falls after 255 REQ cycles; ioctl_din=8'hFF, err_timeout=1.
- Read 1024 sequential bytes, then drop ioctl_upload -> byte_count=1024, a single upload_done pulse one cycle after the drop, no request overlap (DONE gap present).
- Drop ioctl_upload in the 2nd REQ cycle, then assert RESET mid-REQ in a second run -> mem_rd/ioctl_wait low next cycle, FSM in IDLE, count not incremented; after reset all outputs 0.
